ece385_io_key: RTL and testbench



---
 rtl/ece385_io_pkg.sv | 14 +
 rtl/ece385_input_debounce.sv | 59 +++++
 rtl/ece385_io_key.sv | 106 ++++++++++
 tb/tb_ece385_io_key.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ece385_io_pkg.sv
// ece385_io_pkg: constants shared by the ece385 input PIO.
//   ADDR_*  : word addresses of the slave registers
//   EDGE_*  : encodings for the EDGE_TYPE parameter of ece385_io_key
package ece385_io_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;

   localparam int unsigned EDGE_RISING  = 0;
   localparam int unsigned EDGE_FALLING = 1;
   localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/ece385_input_debounce.sv
// ece385_input_debounce: one asynchronous input bit through a 2-flop
// synchronizer and a debounce counter.
//   clk, reset_n : system clock, asynchronous active-low reset
//   in_async     : raw board input
//   stable       : debounced level; takes a new value only after the
//                  synchronized input has differed from it for
//                  DEBOUNCE_CYCLES consecutive cycles (0 = follow directly)
module ece385_input_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_async,
   output logic stable
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   // Count value on the cycle the mismatch reaches DEBOUNCE_CYCLES.
   localparam logic [CNT_W-1:0] CNT_LAST =
      (DEBOUNCE_CYCLES < 1) ? '0 : CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = in_async;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      if (DEBOUNCE_CYCLES == 0) begin
         stable_d = sync2_q;
      end else if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/ece385_io_key.sv
// ece385_io_key: Avalon-MM slave input PIO for push-buttons / switches.
//   clk, reset_n : system clock, asynchronous active-low reset
//   address      : word address (0 data RO, 2 irqmask RW, 3 edgecapture W1C)
//   chipselect   : slave select
//   write_n      : active-low write strobe
//   writedata    : write data (low WIDTH bits used)
//   in_port      : asynchronous board inputs, debounced per bit
//   readdata     : registered read data, latency 1, zero-extended
//   irq          : level interrupt, |(edgecapture & irqmask), registered
module ece385_io_key
   import ece385_io_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned EDGE_TYPE       = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] w1c;
   logic             wr_en;
   logic             unused_wdata;

   // Upper writedata bits are don't-care for a narrow port.
   assign unused_wdata = ^writedata;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      ece385_input_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk      (clk),
         .reset_n  (reset_n),
         .in_async (in_port[g]),
         .stable   (stable[g])
      );
   end

   always_comb begin
      stable_dly_d = stable;
      wr_en        = chipselect && !write_n;

      if (EDGE_TYPE == EDGE_RISING) begin
         edge_hit = stable & ~stable_dly_q;
      end else if (EDGE_TYPE == EDGE_FALLING) begin
         edge_hit = ~stable & stable_dly_q;
      end else begin
         edge_hit = stable ^ stable_dly_q;
      end

      irqmask_d = irqmask_q;
      if (wr_en && (address == ADDR_IRQMASK)) begin
         irqmask_d = writedata[WIDTH-1:0];
      end

      w1c = '0;
      if (wr_en && (address == ADDR_EDGECAP)) begin
         w1c = writedata[WIDTH-1:0];
      end
      // OR-ing the new edge after the clear lets a same-cycle edge win.
      edgecap_d = (edgecap_q & ~w1c) | edge_hit;

      case (address)
         ADDR_DATA:    readdata_d = 32'(stable);
         ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
         ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
         default:      readdata_d = '0;
      endcase

      irq_d = |(edgecap_q & irqmask_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_dly_q <= '0;
         irqmask_q    <= '0;
         edgecap_q    <= '0;
         readdata_q   <= '0;
         irq_q        <= 1'b0;
      end else begin
         stable_dly_q <= stable_dly_d;
         irqmask_q    <= irqmask_d;
         edgecap_q    <= edgecap_d;
         readdata_q   <= readdata_d;
         irq_q        <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_ece385_io_key.sv
module tb_ece385_io_key;

   localparam int OP_RD = 0;
   localparam int OP_WR = 1;
   localparam int OP_IN = 2;

   typedef struct {
      int          op;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int total = 0;
   int bad   = 0;
   vec_t tbl[$];

   ece385_io_key #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .EDGE_TYPE       (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(int op, logic [2:0] a, logic [31:0] d,
                               logic [31:0] er, logic ei);
      vec_t v;
      v.op = op; v.addr = a; v.data = d; v.exp_rd = er; v.exp_irq = ei;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_rd(input logic [2:0] a, input logic [31:0] er, input logic ei,
                        input string name);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      tick();
      chk({name, " rd"}, readdata, er);
      chk({name, " irq"}, 32'(irq), 32'(ei));
      chipselect = 1'b0; address = 3'd0;
   endtask

   task automatic do_wr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] er,
                        input logic ei, input string name);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chk({name, " rd"}, readdata, er);
      chk({name, " irq"}, 32'(irq), 32'(ei));
      chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
   endtask

   task automatic set_in(input logic [3:0] v, input int n);
      in_port = v;
      repeat (n) tick();
   endtask

   initial begin
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = '0;

      // reset held: outputs stay cleared while inputs toggle
      for (int i = 0; i < 5; i++) begin
         in_port = 4'(i * 5 + 3);
         tick();
         chk("reset rd", readdata, 32'h0);
         chk("reset irq", 32'(irq), 32'h0);
      end
      in_port = 4'h0;
      tick();
      #3 reset_n = 1'b1;

      // register map, masking and W1C scenario
      tbl.push_back(mk(OP_RD, 3'd0, 32'h0,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd2, 32'h0,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd3, 32'h0,        32'h0, 1'b0));
      tbl.push_back(mk(OP_IN, 3'd0, 32'hF,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd0, 32'h0,        32'hF, 1'b0));
      tbl.push_back(mk(OP_WR, 3'd0, 32'hFFFFFFFF, 32'hF, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd0, 32'h0,        32'hF, 1'b0));
      tbl.push_back(mk(OP_WR, 3'd2, 32'hFFFFFFF0, 32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd2, 32'h0,        32'h0, 1'b0));
      tbl.push_back(mk(OP_WR, 3'd5, 32'hFFFFFFFF, 32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd1, 32'h0,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd5, 32'h0,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd7, 32'h0,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd2, 32'h0,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd3, 32'h0,        32'h0, 1'b0));
      tbl.push_back(mk(OP_WR, 3'd2, 32'h1,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd2, 32'h0,        32'h1, 1'b0));
      tbl.push_back(mk(OP_WR, 3'd2, 32'h0,        32'h1, 1'b0));
      tbl.push_back(mk(OP_IN, 3'd0, 32'h9,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd3, 32'h0,        32'h6, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd0, 32'h0,        32'h9, 1'b0));
      tbl.push_back(mk(OP_WR, 3'd2, 32'h4,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd2, 32'h0,        32'h4, 1'b1));
      tbl.push_back(mk(OP_WR, 3'd3, 32'h4,        32'h6, 1'b1));
      tbl.push_back(mk(OP_RD, 3'd3, 32'h0,        32'h2, 1'b0));
      tbl.push_back(mk(OP_IN, 3'd0, 32'hF,        32'h0, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd3, 32'h0,        32'h2, 1'b0));
      tbl.push_back(mk(OP_RD, 3'd0, 32'h0,        32'hF, 1'b0));

      for (int i = 0; i < tbl.size(); i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         case (tbl[i].op)
            OP_RD:   do_rd(tbl[i].addr, tbl[i].exp_rd, tbl[i].exp_irq, nm);
            OP_WR:   do_wr(tbl[i].addr, tbl[i].data, tbl[i].exp_rd, tbl[i].exp_irq, nm);
            default: set_in(tbl[i].data[3:0], 10);
         endcase
      end

      // 3-cycle glitch on bit0 is rejected
      in_port = 4'hE;
      repeat (3) tick();
      set_in(4'hF, 10);
      do_rd(3'd0, 32'hF, 1'b0, "glitch data");
      do_rd(3'd3, 32'h2, 1'b0, "glitch cap");

      // bit0 press: data visible exactly 7 cycles after the change, irq one later
      do_wr(3'd2, 32'h1, 32'h4, 1'b0, "mask1");
      address = 3'd0;
      in_port = 4'hE;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 6) chk("press data c6", readdata, 32'hF);
         if (k == 7) begin
            chk("press data c7", readdata, 32'hE);
            chk("press irq c7", 32'(irq), 32'h0);
         end
      end
      tick();
      chk("press irq c8", 32'(irq), 32'h1);
      do_rd(3'd3, 32'h3, 1'b1, "press cap");

      // W1C clears bit0, irq drops one cycle later
      do_wr(3'd3, 32'h1, 32'h3, 1'b1, "w1c bit0");
      do_rd(3'd3, 32'h2, 1'b0, "after w1c");
      set_in(4'hF, 10);

      // collision: W1C of bit2 on the edge its falling edge is captured
      address = 3'd0;
      in_port = 4'hB;
      repeat (6) tick();
      chk("coll data c6", readdata, 32'hF);
      do_wr(3'd3, 32'h6, 32'h2, 1'b0, "coll w1c");
      do_rd(3'd3, 32'h4, 1'b0, "coll keep");
      do_wr(3'd3, 32'h4, 32'h4, 1'b0, "coll w1c2");
      do_rd(3'd3, 32'h0, 1'b0, "coll clr");

      // async reset with irq high
      do_wr(3'd2, 32'h4, 32'h1, 1'b0, "mask4");
      set_in(4'hF, 10);
      set_in(4'hB, 10);
      do_rd(3'd3, 32'h4, 1'b1, "pre reset");
      #3 reset_n = 1'b0;
      #1;
      chk("async irq", 32'(irq), 32'h0);
      chk("async rd", readdata, 32'h0);
      repeat (2) tick();
      #3 reset_n = 1'b1;
      do_rd(3'd0, 32'h0, 1'b0, "post data");
      do_rd(3'd2, 32'h0, 1'b0, "post mask");
      do_rd(3'd3, 32'h0, 1'b0, "post cap");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
